// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if
// Bundles the signals between the fetch controller, its program memory, the
// decoder and the sequencing logic that starts and redirects execution.
//
//   start          pulse that begins or restarts execution
//   stall          decoder not ready
//   branch_valid   redirect request (held by the requester)
//   branch_target  redirect address
//   mem_addr       program memory address
//   mem_data       program memory read data, one cycle after mem_addr
//   instr          registered instruction to the decoder
//   instr_pc       address of instr
//   instr_valid    instr/instr_pc valid
//   halted         controller is parked after a halt instruction
//
// master: the fetch controller. slave: memory, decoder and sequencer side.
// ----------------------------------------------------------------------------
interface fetch_if #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 11
);
    logic                     start;
    logic                     stall;
    logic                     branch_valid;
    logic [RAM_ADDR_BITS-1:0] branch_target;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0]     mem_data;
    logic [RAM_WIDTH-1:0]     instr;
    logic [RAM_ADDR_BITS-1:0] instr_pc;
    logic                     instr_valid;
    logic                     halted;

    modport master (
        input  start, stall, branch_valid, branch_target, mem_data,
        output mem_addr, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, stall, branch_valid, branch_target, mem_data,
        input  mem_addr, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer: owns the program counter, addresses a
// synchronous-read program memory (data one cycle after address) and
// delivers a registered instruction stream, handling decoder stalls,
// branches, halt and restart.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_if.master (start/stall/branch in, memory address out,
//          memory data in, instruction stream and halted out)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, nothing fetched
// FILL  | first word requested, nothing captured yet
// RUN   | streaming one instruction per cycle
// HALT  | halt instruction consumed, waiting for start
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter int                     RAM_WIDTH     = 16,
    parameter int                     RAM_ADDR_BITS = 11,
    parameter int                     OPCODE_BITS   = 5,
    parameter logic [OPCODE_BITS-1:0] HALT_OPCODE   = '0,
    parameter int                     RESET_PC      = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    localparam logic [RAM_ADDR_BITS-1:0] LP_RESET_PC = RAM_ADDR_BITS'(RESET_PC);
    localparam logic [RAM_ADDR_BITS-1:0] LP_ONE      = RAM_ADDR_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                   r_state;
    logic [RAM_ADDR_BITS-1:0] r_fetch_pc;
    logic [RAM_ADDR_BITS-1:0] r_data_addr;
    logic                     r_pend;
    logic [RAM_WIDTH-1:0]     r_instr;
    logic [RAM_ADDR_BITS-1:0] r_instr_pc;
    logic                     r_instr_valid;
    logic                     r_halted;

    state_t                   w_state_nxt;
    logic [RAM_ADDR_BITS-1:0] w_fetch_pc_nxt;
    logic                     w_pend_nxt;
    logic [RAM_WIDTH-1:0]     w_instr_nxt;
    logic [RAM_ADDR_BITS-1:0] w_instr_pc_nxt;
    logic                     w_instr_valid_nxt;
    logic                     w_halted_nxt;
    logic [RAM_ADDR_BITS-1:0] w_mem_addr;
    logic                     w_start_ok;
    logic                     w_branch_ok;
    logic                     w_is_halt;

    always_comb begin
        w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_HALT));
        w_branch_ok = bus.branch_valid && !bus.stall &&
                      ((r_state == S_FILL) || (r_state == S_RUN));
        w_is_halt   = r_instr_valid &&
                      (r_instr[RAM_WIDTH-1 -: OPCODE_BITS] == HALT_OPCODE);

        // Re-presenting the captured address during a stall keeps mem_data
        // stable for however long the decoder holds off.
        if (bus.stall && r_pend) begin
            w_mem_addr = r_data_addr;
        end else if (w_branch_ok) begin
            w_mem_addr = bus.branch_target;
        end else if (w_start_ok) begin
            w_mem_addr = LP_RESET_PC;
        end else begin
            w_mem_addr = r_fetch_pc;
        end

        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_pend_nxt        = r_pend;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_halted_nxt      = r_halted;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (w_start_ok) begin
                    w_state_nxt    = S_FILL;
                    w_fetch_pc_nxt = LP_RESET_PC + LP_ONE;
                    w_pend_nxt     = 1'b1;
                    w_halted_nxt   = 1'b0;
                end
            end
            S_FILL: begin
                // A stall here just re-reads the same word; a branch restarts
                // the fill from the new target.
                if (!bus.stall) begin
                    if (w_branch_ok) begin
                        w_fetch_pc_nxt = bus.branch_target + LP_ONE;
                    end else begin
                        w_state_nxt       = S_RUN;
                        w_instr_nxt       = bus.mem_data;
                        w_instr_pc_nxt    = r_data_addr;
                        w_instr_valid_nxt = 1'b1;
                        w_fetch_pc_nxt    = r_fetch_pc + LP_ONE;
                    end
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (w_branch_ok) begin
                        // The word in flight belongs to the old path.
                        w_fetch_pc_nxt    = bus.branch_target + LP_ONE;
                        w_instr_valid_nxt = 1'b0;
                        w_pend_nxt        = 1'b1;
                    end else if (w_is_halt) begin
                        w_state_nxt       = S_HALT;
                        w_instr_valid_nxt = 1'b0;
                        w_halted_nxt      = 1'b1;
                        w_pend_nxt        = 1'b0;
                    end else begin
                        w_instr_nxt       = bus.mem_data;
                        w_instr_pc_nxt    = r_data_addr;
                        w_instr_valid_nxt = r_pend;
                        w_fetch_pc_nxt    = r_fetch_pc + LP_ONE;
                        w_pend_nxt        = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= LP_RESET_PC;
            r_data_addr   <= '0;
            r_pend        <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_data_addr   <= w_mem_addr;
            r_pend        <= w_pend_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign bus.mem_addr    = w_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_fetch_controller
// Drives fetch_controller through directed scenarios and a randomized run,
// comparing against a stream-level reference model: the model tracks which
// program address should be delivered next and applies start / stall /
// branch / halt rules directly, with its own program memory array.
// ----------------------------------------------------------------------------
module tb_fetch_controller;
    localparam int W = 16;
    localparam int A = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus();

    fetch_controller #(
        .RAM_WIDTH    (W),
        .RAM_ADDR_BITS(A),
        .OPCODE_BITS  (5),
        .HALT_OPCODE  (5'b00000),
        .RESET_PC     (0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Program memory: synchronous read, data one cycle after address.
    logic [W-1:0] ram [0:(1<<A)-1];
    always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit           m_running;
    bit           m_valid;
    bit           m_halted;
    logic [A-1:0] m_ipc;
    logic [W-1:0] m_instr;
    logic [A-1:0] m_next;
    logic [A-1:0] m_park;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_valid = 0; m_halted = 0;
        m_ipc = '0; m_instr = '0; m_next = '0; m_park = '0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit br, input logic [A-1:0] tg);
        if (!m_running) begin
            if (st) begin
                m_running = 1; m_halted = 0; m_valid = 0; m_next = '0;
            end
        end else if (sl) begin
            // decoder stalled: nothing moves
        end else if (br) begin
            m_valid = 0;
            m_next  = tg;
        end else if (m_valid && m_instr[W-1:W-5] == 5'b00000) begin
            m_running = 0; m_valid = 0; m_halted = 1;
            m_park = m_next + 11'd1;
        end else begin
            m_valid = 1;
            m_ipc   = m_next;
            m_instr = ram[m_next];
            m_next  = m_next + 11'd1;
        end
    endtask

    // One clock: apply inputs, check the address, clock, check the outputs.
    task automatic cycle(input bit st, input bit sl, input bit br, input logic [A-1:0] tg);
        logic [A-1:0] exp_addr;
        bus.start = st; bus.stall = sl; bus.branch_valid = br; bus.branch_target = tg;
        #2;
        if (m_running) exp_addr = sl ? m_next : (br ? tg : m_next + 11'd1);
        else           exp_addr = st ? 11'd0 : m_park;
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        @(posedge clk);
        model_step(st, sl, br, tg);
        #1;
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        check("halted", 32'(bus.halted), 32'(m_halted));
        if (m_valid) begin
            check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
            check("instr", 32'(bus.instr), 32'(m_instr));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic async_reset(input bit sl);
        bus.start = 0; bus.stall = sl; bus.branch_valid = 0; bus.branch_target = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        #3 rst_n = 1'b1;
    endtask

    task automatic run_until_pc(input logic [A-1:0] target);
        int n = 0;
        while (!(m_valid && m_ipc == target) && n < 64) begin
            cycle(0, 0, 0, '0);
            n++;
        end
        check("reach_pc", 32'(bus.instr_pc), 32'(target));
    endtask

    initial begin
        bus.start = 0; bus.stall = 0; bus.branch_valid = 0; bus.branch_target = '0;
        for (int i = 0; i < (1 << A); i++) ram[i] = W'($urandom) | 16'h0800;
        ram[0] = 16'h0801; ram[1] = 16'h0802; ram[2] = 16'h0803; ram[3] = 16'h0000;
        model_reset();

        #12;
        check("por_valid", 32'(bus.instr_valid), 32'd0);
        check("por_halted", 32'(bus.halted), 32'd0);
        check("por_instr", 32'(bus.instr), 32'd0);
        check("por_mem_addr", 32'(bus.mem_addr), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Straight-line program ending in HALT at address 3.
        idle(2);
        cycle(1, 0, 0, '0);
        idle(6);
        check("halt_reached", 32'(bus.halted), 32'd1);

        // Restart from HALT, then stall 3 cycles while instr_pc=1.
        cycle(1, 0, 0, '0);
        idle(2);
        check("stall_pre_pc", 32'(bus.instr_pc), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0);
        check("stall_hold_instr", 32'(bus.instr), 32'h0802);
        idle(1);
        check("stall_release_pc", 32'(bus.instr_pc), 32'd2);
        idle(4);

        // Branch to 0x100 while instr_pc=5.
        ram[3] = 16'h0804;
        async_reset(0);
        cycle(1, 0, 0, '0);
        run_until_pc(11'd5);
        cycle(0, 0, 1, 11'h100);
        check("branch_bubble", 32'(bus.instr_valid), 32'd0);
        idle(1);
        check("branch_target_pc", 32'(bus.instr_pc), 32'h100);
        idle(1);
        check("branch_next_pc", 32'(bus.instr_pc), 32'h101);

        // Back-to-back branches, then wrap-around from 0x7FE.
        cycle(0, 0, 1, 11'h200);
        cycle(0, 0, 1, 11'h7FE);
        idle(3);
        check("wrap_pc", 32'(bus.instr_pc), 32'h000);

        // Start while running is ignored; branch under stall is ignored.
        cycle(1, 0, 0, '0);
        cycle(0, 1, 1, 11'h333);
        idle(2);

        // Async reset mid-run, then during a stall.
        async_reset(0);
        idle(3);
        cycle(1, 0, 0, '0);
        idle(2);
        cycle(0, 1, 0, '0);
        async_reset(1);
        idle(2);

        // Randomized run over a fresh program image containing halts.
        for (int i = 0; i < (1 << A); i++) ram[i] = W'($urandom);
        for (int i = 0; i < 3000; i++) begin
            bit st, sl, br;
            logic [A-1:0] tg;
            st = m_running ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 7) == 0);
            tg = A'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset(sl);
            else cycle(st, sl, br, tg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
